// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read port bundle for the multi-port register file
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic                  WE0;
    logic [AW-1:0]         WADDR0;
    logic [XLEN-1:0]       WDATA0;
    logic                  WE1;
    logic [AW-1:0]         WADDR1;
    logic [XLEN-1:0]       WDATA1;
    logic [NREAD*AW-1:0]   RADDR;
    logic [NREAD*XLEN-1:0] RDATA;
    logic                  BUSY;

    modport master (
        output WE0, WADDR0, WDATA0, WE1, WADDR1, WDATA1, RADDR,
        input  RDATA, BUSY
    );

    modport slave (
        input  WE0, WADDR0, WDATA0, WE1, WADDR1, WDATA1, RADDR,
        output RDATA, BUSY
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with prioritised writes, bypass and clear sequencer
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    regfile_mp_if.slave  bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state;
    logic [AW-1:0]         cnt;
    logic                  busy;
    logic [XLEN-1:0]       mem [DEPTH];
    logic [NREAD*XLEN-1:0] rdata;
    logic [AW-1:0]         ra;
    logic                  acc0;
    logic                  acc1;

    // An address is usable when it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign acc0 = bus.WE0 && addr_ok(bus.WADDR0);
    assign acc1 = bus.WE1 && addr_ok(bus.WADDR1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // Port 1 is applied last so it wins a same-address collision.
                    if (acc0) mem[bus.WADDR0] <= bus.WDATA0;
                    if (acc1) mem[bus.WADDR1] <= bus.WDATA1;
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        ra    = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = bus.RADDR[k*AW +: AW];
            if (!busy && addr_ok(ra)) begin
                if ((BYPASS != 0) && bus.WE1 && (bus.WADDR1 == ra))
                    rdata[k*XLEN +: XLEN] = bus.WDATA1;
                else if ((BYPASS != 0) && bus.WE0 && (bus.WADDR0 == ra))
                    rdata[k*XLEN +: XLEN] = bus.WDATA0;
                else
                    rdata[k*XLEN +: XLEN] = mem[ra];
            end
        end
    end

    assign bus.RDATA = rdata;
    assign bus.BUSY  = busy;
endmodule
